if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_if.sv | 28 ++
 rtl/if_id_queue.sv | 76 +++++++
 tb/tb_if_id_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID queue.
// The queue connects through the slave modport; fetch/decode logic uses master.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            out_valid;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic            out_ready;
    logic            flush;
    logic [CntW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: small in-order FIFO of pc/instruction pairs with flush.
// Empty queue presents pc 0 and a NOP so decode never sees stale storage.
module if_id_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic full, empty, push, pop;

    // in_ready deliberately ignores out_ready: a full queue never pushes in a pop cycle.
    always_comb begin
        full  = (count_q == CntW'(DEPTH));
        empty = (count_q == '0);
        push  = bus.in_valid && !full && !bus.flush;
        pop   = bus.out_ready && !empty && !bus.flush;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; the outputs are masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= bus.in_pc;
            instr_mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    always_comb begin
        bus.in_ready  = !full && !bus.flush;
        bus.out_valid = !empty;
        bus.out_pc    = empty ? 32'h0 : pc_mem_q[rd_ptr_q];
        bus.out_instr = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];
        bus.count     = count_q;
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/stall, streaming, flush, wrap and async reset.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr_of(pc);
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] cnt, input logic [31:0] pc);
        check({tag, "_count"}, 32'(bus.count), cnt);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(cnt != 0));
        check({tag, "_pc"}, bus.out_pc, (cnt != 0) ? pc : 32'h0);
        check({tag, "_instr"}, bus.out_instr, (cnt != 0) ? instr_of(pc) : NOP);
    endtask

    initial begin
        // Reset held with a push pending: nothing may enter.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        repeat (2) step();
        expect_head("rst_hold", 0, 32'h0);
        check("rst_hold_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        #1;
        expect_head("rst_rel_pre_edge", 0, 32'h0);
        step();
        expect_head("rst_rel_first", 1, 32'h100);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_head("rst_rel_drain", 0, 32'h0);

        // Fill and stall.
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        expect_head("fill0", 1, 32'h0);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        step();
        expect_head("fill1", 2, 32'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        #1;
        check("fill_full_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        expect_head("fill_stall", 2, 32'h0);
        check("fill_stall_in_ready", 32'(bus.in_ready), 32'd0);
        // Full queue with a pop: 0x8 still refused.
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        expect_head("full_pop", 1, 32'h4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_head("fill_drain", 0, 32'h0);

        // Streaming: push+pop every cycle once one entry is held.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            step();
            expect_head($sformatf("stream%0d", i), 1, 32'h200 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_head("stream_drain", 0, 32'h0);

        // Flush wins over a concurrent push and pop.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        step();
        expect_head("pre_flush", 2, 32'h10);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        expect_head("flush", 0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_head("flush_no_0x40", 0, 32'h0);
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        step();
        expect_head("post_flush", 1, 32'h80);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_head("post_flush_drain", 0, 32'h0);

        // Wrap: alternate push-only and pop-only; pointers wrap several times.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1'b1, 32'h500 + 32'(16 * i), 1'b0, 1'b0);
            step();
            expect_head($sformatf("wrap_push%0d", i), 1, 32'h500 + 32'(16 * i));
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
            expect_head($sformatf("wrap_pop%0d", i), 0, 32'h0);
        end

        // Async reset between edges with two entries queued.
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h604, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        expect_head("pre_async_rst", 2, 32'h600);
        #2;
        rst = 1'b0;
        #1;
        expect_head("async_rst", 0, 32'h0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step();
        expect_head("after_async_rst", 1, 32'h300);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_head("after_async_rst_hold", 1, 32'h300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
